neuron_driver: RTL and testbench

- Initiator-side controller for the team's Artificial_Neuron block; it drives the neuron's activation_input, weight, bias and load_params ports and reads its res port.
- Accepts a serial configuration stream (m weight beats, then one bias beat) and assembles the packed weight and bias vectors.
- Issues a one-cycle load_params commit, then runs inferences one at a time: activation vector in, ReLU result out, with valid/ready on both sides.

---
 rtl/neuron_driver_pkg.sv | 26 ++
 rtl/neuron_driver_if.sv | 47 ++++
 rtl/neuron_cfg_assembler.sv | 71 +++++++
 rtl/neuron_driver.sv | 122 ++++++++++++
 tb/tb_neuron_driver.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/neuron_driver_pkg.sv
// Shared definitions for the neuron_driver block.
//   state_e          : driver FSM state encoding
//   calc_res_width() : width of the Artificial_Neuron result for given lane sizes
//   max_int()        : helper used to size the configuration beat
package neuron_driver_pkg;

  typedef enum logic [2:0] {
    ST_CFG    = 3'd0,
    ST_COMMIT = 3'd1,
    ST_RUN    = 3'd2,
    ST_FLY1   = 3'd3,
    ST_FLY2   = 3'd4,
    ST_HOLD   = 3'd5
  } state_e;

  // Largest magnitude the neuron can produce is m full-scale products plus
  // a full-scale bias; the result port is sized to hold that.
  function automatic int calc_res_width(input int k, input int n, input int b, input int m);
    return $clog2(m * ((2 ** k) - 1) * ((2 ** n) - 1) + (2 ** b) - 1);
  endfunction

  function automatic int max_int(input int a, input int c);
    return (a > c) ? a : c;
  endfunction

endpackage

// File: rtl/neuron_driver_if.sv
// Bundle of every non-clock signal of neuron_driver.
//   master : the driver itself (accepts cfg/act streams, produces results,
//            drives the neuron parameter/activation ports, reads nrn_res)
//   slave  : the surrounding system plus the neuron
// Streams: cfg_* (config beats), act_* (activation vectors), out_* (results),
// nrn_* (connection to Artificial_Neuron).
interface neuron_driver_if #(
  parameter int k = 4,
  parameter int n = 4,
  parameter int b = 4,
  parameter int m = 4
) ();
  import neuron_driver_pkg::*;

  localparam int res_width = calc_res_width(k, n, b, m);
  localparam int CW        = max_int(n, b);

  logic                 cfg_start;
  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [CW-1:0]        cfg_data;
  logic                 act_valid;
  logic                 act_ready;
  logic [m*k-1:0]       act_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [res_width-1:0] out_data;
  logic                 configured;
  logic [m*k-1:0]       nrn_act;
  logic [m*n-1:0]       nrn_weight;
  logic [b-1:0]         nrn_bias;
  logic                 nrn_load_params;
  logic [res_width-1:0] nrn_res;

  modport master (
    input  cfg_start, cfg_valid, cfg_data, act_valid, act_data, out_ready, nrn_res,
    output cfg_ready, act_ready, out_valid, out_data, configured,
           nrn_act, nrn_weight, nrn_bias, nrn_load_params
  );

  modport slave (
    output cfg_start, cfg_valid, cfg_data, act_valid, act_data, out_ready, nrn_res,
    input  cfg_ready, act_ready, out_valid, out_data, configured,
           nrn_act, nrn_weight, nrn_bias, nrn_load_params
  );

endinterface

// File: rtl/neuron_cfg_assembler.sv
// Collects the serial configuration stream into packed weight/bias vectors.
//   wr_en  : accepted beat strobe;  clr : restart at beat 0
//   data   : beat payload (low n bits = weight lane, low b bits = bias)
//   weight : packed lanes, lane i at [(i+1)n-1:in];  bias : bias value
//   last   : the next beat is the bias beat
module neuron_cfg_assembler #(
  parameter int n  = 4,
  parameter int b  = 4,
  parameter int m  = 4,
  parameter int CW = 4
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           wr_en,
  input  logic           clr,
  input  logic [CW-1:0]  data,
  output logic [m*n-1:0] weight,
  output logic [b-1:0]   bias,
  output logic           last
);

  localparam int CNT_W = $clog2(m + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [b-1:0]     bias_q, bias_d;

  assign last = (cnt_q == CNT_W'(m));

  // Writing the bias beat wraps the counter so the next session starts clean.
  always_comb begin
    cnt_d  = cnt_q;
    bias_d = bias_q;
    if (clr) begin
      cnt_d = '0;
    end else if (wr_en) begin
      cnt_d = last ? '0 : cnt_q + CNT_W'(1);
      if (last) bias_d = data[b-1:0];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q  <= '0;
      bias_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      bias_q <= bias_d;
    end
  end

  generate
    for (genvar gi = 0; gi < m; gi++) begin : g_lane
      logic [n-1:0] lane_q, lane_d;

      always_comb begin
        lane_d = lane_q;
        if (wr_en && !clr && (cnt_q == CNT_W'(gi))) lane_d = data[n-1:0];
      end

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) lane_q <= '0;
        else       lane_q <= lane_d;
      end

      assign weight[gi*n +: n] = lane_q;
    end
  endgenerate

  assign bias = bias_q;

endmodule

// File: rtl/neuron_driver.sv
// Initiator-side controller for Artificial_Neuron.
//   clk, rstn : clock, asynchronous active-low reset
//   bus       : neuron_driver_if.master (cfg/act/out streams and nrn_* ports)
// Flow: CFG (m weight beats + bias beat) -> COMMIT (one-cycle load_params)
// -> RUN; each activation handshake walks FLY1/FLY2 while the neuron
// captures and settles, the result is registered and held in HOLD until
// out_ready.
module neuron_driver
  import neuron_driver_pkg::*;
#(
  parameter int k = 4,
  parameter int n = 4,
  parameter int b = 4,
  parameter int m = 4
) (
  input  logic clk,
  input  logic rstn,
  neuron_driver_if.master bus
);

  localparam int res_width = calc_res_width(k, n, b, m);
  localparam int CW        = max_int(n, b);

  state_e               state_q, state_d;
  logic [m*k-1:0]       nrn_act_q, nrn_act_d;
  logic [res_width-1:0] out_data_q, out_data_d;
  logic                 out_valid_q, out_valid_d;
  logic                 configured_q, configured_d;

  logic                 cfg_wr;
  logic                 cfg_clr;
  logic                 cfg_last;
  logic [m*n-1:0]       weight;
  logic [b-1:0]         bias;

  neuron_cfg_assembler #(.n(n), .b(b), .m(m), .CW(CW)) u_cfg (
    .clk    (clk),
    .rstn   (rstn),
    .wr_en  (cfg_wr),
    .clr    (cfg_clr),
    .data   (bus.cfg_data),
    .weight (weight),
    .bias   (bias),
    .last   (cfg_last)
  );

  always_comb begin
    state_d         = state_q;
    nrn_act_d       = nrn_act_q;
    out_data_d      = out_data_q;
    out_valid_d     = out_valid_q;
    configured_d    = configured_q;
    cfg_wr          = 1'b0;
    cfg_clr         = 1'b0;
    bus.cfg_ready       = 1'b0;
    bus.act_ready       = 1'b0;
    bus.nrn_load_params = 1'b0;

    unique case (state_q)
      ST_CFG: begin
        bus.cfg_ready = 1'b1;
        if (bus.cfg_valid) begin
          cfg_wr = 1'b1;
          if (cfg_last) state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        bus.nrn_load_params = 1'b1;
        configured_d        = 1'b1;
        state_d             = ST_RUN;
      end
      ST_RUN: begin
        bus.act_ready = 1'b1;
        // An activation arriving with cfg_start takes priority.
        if (bus.act_valid) begin
          nrn_act_d = bus.act_data;
          state_d   = ST_FLY1;
        end else if (bus.cfg_start) begin
          cfg_clr = 1'b1;
          state_d = ST_CFG;
        end
      end
      ST_FLY1: state_d = ST_FLY2;   // neuron registers nrn_act this edge
      ST_FLY2: begin                // nrn_res valid combinationally now
        out_data_d  = bus.nrn_res;
        out_valid_d = 1'b1;
        state_d     = ST_HOLD;
      end
      ST_HOLD: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_RUN;
        end
      end
      default: state_d = ST_CFG;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_CFG;
      nrn_act_q    <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      configured_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      nrn_act_q    <= nrn_act_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      configured_q <= configured_d;
    end
  end

  assign bus.nrn_act    = nrn_act_q;
  assign bus.nrn_weight = weight;
  assign bus.nrn_bias   = bias;
  assign bus.out_data   = out_data_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.configured = configured_q;

endmodule

// File: tb/tb_neuron_driver.sv
// Directed bench for neuron_driver with a behavioural Artificial_Neuron model.
module tb_neuron_driver;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  neuron_driver_if #(.k(4), .n(4), .b(4), .m(4)) bus ();

  neuron_driver #(.k(4), .n(4), .b(4), .m(4)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // Neuron model: parameters load on load_params, activation registered
  // every cycle, result combinational from the registered values.
  logic [15:0] mdl_w = '0;
  logic [15:0] mdl_a = '0;
  logic [3:0]  mdl_b = '0;

  always @(posedge clk) begin
    if (bus.nrn_load_params) begin
      mdl_w <= bus.nrn_weight;
      mdl_b <= bus.nrn_bias;
    end
    mdl_a <= bus.nrn_act;
  end

  function automatic logic [9:0] neuron_f(input logic [15:0] a, input logic [15:0] w,
                                          input logic [3:0] bb);
    int s;
    s = int'($signed(bb));
    for (int i = 0; i < 4; i++)
      s += int'($signed(a[i*4 +: 4])) * int'($signed(w[i*4 +: 4]));
    if (s < 0) s = 0;
    return s[9:0];
  endfunction

  assign bus.nrn_res = neuron_f(mdl_a, mdl_w, mdl_b);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Five back-to-back beats then the commit cycle.
  task automatic do_config(input logic [15:0] w, input logic [3:0] bias);
    check("cfg_ready_before_cfg", {31'd0, bus.cfg_ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      bus.cfg_valid = 1'b1;
      bus.cfg_data  = w[i*4 +: 4];
      tick();
      check("no_load_mid_cfg", {31'd0, bus.nrn_load_params}, 32'd0);
      check("act_ready_mid_cfg", {31'd0, bus.act_ready}, 32'd0);
    end
    bus.cfg_data = bias;
    tick();
    bus.cfg_valid = 1'b0;
    check("load_pulse", {31'd0, bus.nrn_load_params}, 32'd1);
    check("nrn_weight", {16'd0, bus.nrn_weight}, {16'd0, w});
    check("nrn_bias", {28'd0, bus.nrn_bias}, {28'd0, bias});
    tick();
    check("load_one_cycle", {31'd0, bus.nrn_load_params}, 32'd0);
    check("configured", {31'd0, bus.configured}, 32'd1);
    check("act_ready_after_commit", {31'd0, bus.act_ready}, 32'd1);
    $display("[TB] config weight=%h bias=%h", w, bias);
  endtask

  task automatic run_inf(input logic [15:0] act, input logic [9:0] exp,
                         input int hold, input logic with_cfg_start);
    int wait_cnt;
    wait_cnt = 0;
    while (!bus.act_ready && wait_cnt < 20) begin
      tick();
      wait_cnt++;
    end
    check("act_ready_wait", {31'd0, bus.act_ready}, 32'd1);
    bus.act_valid = 1'b1;
    bus.act_data  = act;
    bus.cfg_start = with_cfg_start;
    bus.out_ready = (hold == 0);
    tick();                                  // E0
    bus.act_valid = 1'b0;
    bus.cfg_start = 1'b0;
    check("act_ready_drop", {31'd0, bus.act_ready}, 32'd0);
    check("nrn_act", {16'd0, bus.nrn_act}, {16'd0, act});
    check("no_cfg_after_act", {31'd0, bus.cfg_ready}, 32'd0);
    tick();                                  // E1
    check("out_valid_early", {31'd0, bus.out_valid}, 32'd0);
    tick();                                  // E2
    check("out_valid", {31'd0, bus.out_valid}, 32'd1);
    check("out_data", {22'd0, bus.out_data}, {22'd0, exp});
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_valid", {31'd0, bus.out_valid}, 32'd1);
      check("hold_data", {22'd0, bus.out_data}, {22'd0, exp});
      check("hold_act_ready", {31'd0, bus.act_ready}, 32'd0);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("out_valid_drop", {31'd0, bus.out_valid}, 32'd0);
    check("act_ready_return", {31'd0, bus.act_ready}, 32'd1);
    check("nrn_act_held", {16'd0, bus.nrn_act}, {16'd0, act});
    $display("[TB] inference act=%h out=%0d expected=%0d", act, bus.out_data, exp);
  endtask

  task automatic request_cfg();
    bus.cfg_start = 1'b1;
    tick();
    bus.cfg_start = 1'b0;
    check("cfg_start_ready", {31'd0, bus.cfg_ready}, 32'd1);
    check("cfg_start_act_ready", {31'd0, bus.act_ready}, 32'd0);
    check("configured_kept", {31'd0, bus.configured}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cfg_start = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_data  = '0;
    bus.act_valid = 1'b0;
    bus.act_data  = '0;
    bus.out_ready = 1'b0;

    repeat (3) tick();
    check("rst_act_ready", {31'd0, bus.act_ready}, 32'd0);
    check("rst_configured", {31'd0, bus.configured}, 32'd0);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_load", {31'd0, bus.nrn_load_params}, 32'd0);
    check("rst_weight", {16'd0, bus.nrn_weight}, 32'd0);
    rstn = 1'b1;
    tick();
    check("rel_cfg_ready", {31'd0, bus.cfg_ready}, 32'd1);

    // Weights 1,2,3,4 bias 1; act all ones -> 11
    do_config(16'h4321, 4'h1);
    run_inf(16'h1111, 10'd11, 0, 1'b0);
    // Back-pressure for five cycles
    run_inf(16'h1111, 10'd11, 5, 1'b0);

    // Config beats outside CFG are ignored
    bus.cfg_valid = 1'b1;
    bus.cfg_data  = 4'h7;
    tick();
    bus.cfg_valid = 1'b0;
    check("cfg_ignored_weight", {16'd0, bus.nrn_weight}, 32'h4321);
    check("cfg_ignored_run", {31'd0, bus.act_ready}, 32'd1);

    // All weights -1, bias 0 -> -4 clamps to 0
    request_cfg();
    do_config(16'hFFFF, 4'h0);
    run_inf(16'h1111, 10'd0, 0, 1'b0);

    // Weights 2,2,2,2 -> 8; with lane 3 act = -1 -> 4
    request_cfg();
    do_config(16'h2222, 4'h0);
    run_inf(16'h1111, 10'd8, 0, 1'b0);
    run_inf(16'hF111, 10'd4, 0, 1'b1);   // cfg_start dropped in favour of act
    check("no_reconfig_cfg_ready", {31'd0, bus.cfg_ready}, 32'd0);
    check("no_reconfig_weight", {16'd0, bus.nrn_weight}, 32'h2222);

    // Reset after two beats of a new config
    request_cfg();
    bus.cfg_valid = 1'b1;
    bus.cfg_data  = 4'h5;
    tick();
    tick();
    bus.cfg_valid = 1'b0;
    #2 rstn = 1'b0;
    #1;
    check("mid_rst_weight", {16'd0, bus.nrn_weight}, 32'd0);
    check("mid_rst_bias", {28'd0, bus.nrn_bias}, 32'd0);
    check("mid_rst_act", {16'd0, bus.nrn_act}, 32'd0);
    check("mid_rst_out_data", {22'd0, bus.out_data}, 32'd0);
    check("mid_rst_configured", {31'd0, bus.configured}, 32'd0);
    tick();
    rstn = 1'b1;
    repeat (3) begin
      tick();
      check("post_rst_act_ready", {31'd0, bus.act_ready}, 32'd0);
    end
    do_config(16'h2222, 4'h0);
    run_inf(16'h1111, 10'd8, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
